// File: rtl/line_buffer_seq_3x3.sv
// Sequencer for two cascaded line-buffer FIFOs feeding a 3x3 window stage.
// Produces three vertically aligned row taps and border flags per accepted pixel.
module line_buffer_seq_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 11
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              vs_in,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              fifo1_wr_en,
  output logic [DATA_W-1:0] fifo1_wr_data,
  output logic              fifo1_rd_en,
  input  logic [DATA_W-1:0] fifo1_rd_data,
  input  logic              fifo1_full,
  input  logic              fifo1_empty,
  output logic              fifo2_wr_en,
  output logic [DATA_W-1:0] fifo2_wr_data,
  output logic              fifo2_rd_en,
  input  logic [DATA_W-1:0] fifo2_rd_data,
  input  logic              fifo2_empty,
  output logic [DATA_W-1:0] row0_data,
  output logic [DATA_W-1:0] row1_data,
  output logic [DATA_W-1:0] row2_data,
  output logic              taps_valid,
  output logic [CNT_W-1:0]  tap_col,
  output logic [CNT_W-1:0]  tap_row,
  output logic              first_col,
  output logic              last_col,
  output logic              first_row,
  output logic              last_row,
  output logic              seq_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] col_q, row_q;
  logic [1:0] flush_cnt_q;
  logic prev_empty_q, vs_pend_q, rd1_q, rd2_q;
  logic accept, frame_end, early_vs, both_empty, flush_done;
  logic row_ge1, row_ge2, col_last;

  assign accept     = (state_q == ACTIVE) && pix_valid && !vs_in;
  assign early_vs   = (state_q == ACTIVE) && vs_in;
  assign row_ge1    = (row_q != '0);
  assign row_ge2    = row_ge1 && (row_q != CNT_W'(1));
  assign col_last   = (col_q == CNT_W'(IMG_W - 1));
  assign frame_end  = accept && col_last && (row_q == CNT_W'(IMG_H - 1));
  assign both_empty = fifo1_empty && fifo2_empty;
  // Leave FLUSH only after three cycles there and two empty cycles in a row.
  assign flush_done = (flush_cnt_q == 2'd2) && both_empty && prev_empty_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_in) state_d = ACTIVE;
      ACTIVE:  if (early_vs || frame_end) state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = (vs_pend_q || vs_in) ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO1 reads from row 1 onward feed FIFO2 one cycle later; rd1_q carries that write.
  always_comb begin
    fifo1_wr_en   = accept;
    fifo1_wr_data = accept ? pix_data : '0;
    fifo1_rd_en   = 1'b0;
    fifo2_rd_en   = 1'b0;
    fifo2_wr_en   = rd1_q;
    fifo2_wr_data = rd1_q ? fifo1_rd_data : '0;
    if (state_q == ACTIVE) begin
      fifo1_rd_en = accept && row_ge1;
      fifo2_rd_en = accept && row_ge2;
    end else if (state_q == FLUSH) begin
      fifo1_rd_en = !fifo1_empty;
      fifo2_rd_en = !fifo2_empty;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (vs_in || state_q != ACTIVE) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + CNT_W'(1);
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

  // A frame start seen during ACTIVE or FLUSH is held so the drain restarts the frame.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      flush_cnt_q  <= '0;
      prev_empty_q <= 1'b0;
      vs_pend_q    <= 1'b0;
    end else if (state_q == FLUSH) begin
      flush_cnt_q  <= (flush_cnt_q == 2'd2) ? 2'd2 : flush_cnt_q + 2'd1;
      prev_empty_q <= both_empty;
      if (flush_done)  vs_pend_q <= 1'b0;
      else if (vs_in)  vs_pend_q <= 1'b1;
    end else begin
      flush_cnt_q  <= '0;
      prev_empty_q <= 1'b0;
      vs_pend_q    <= early_vs;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      seq_err <= 1'b0;
    end else if (early_vs || (accept && fifo1_full)) begin
      seq_err <= 1'b1;
    end else if (vs_in && (state_q == IDLE || state_q == FLUSH)) begin
      seq_err <= 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      taps_valid <= 1'b0;
      row2_data  <= '0;
      tap_col    <= '0;
      tap_row    <= '0;
      first_col  <= 1'b0;
      last_col   <= 1'b0;
      first_row  <= 1'b0;
      last_row   <= 1'b0;
    end else begin
      rd1_q      <= accept && row_ge1;
      rd2_q      <= accept && row_ge2;
      taps_valid <= accept && row_ge2;
      if (accept) begin
        row2_data <= pix_data;
        tap_col   <= col_q;
        tap_row   <= row_q;
        first_col <= (col_q == '0);
        last_col  <= col_last;
        first_row <= (row_q == '0);
        last_row  <= (row_q == CNT_W'(IMG_H - 1));
      end
    end
  end

  // The FIFOs register their read data, so the older rows line up with row2_data.
  assign row1_data = rd1_q ? fifo1_rd_data : '0;
  assign row0_data = rd2_q ? fifo2_rd_data : '0;

endmodule
